rgb_to_hsv_pipe: RTL and testbench

//  Parametrised, fully pipelined RGB->HSV converter for the video colour-detect path; one pixel/clock.

---
 rtl/hsv_pkg.sv | 15 +
 rtl/hsv_div_pipe.sv | 66 ++++++
 rtl/rgb_to_hsv_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_rgb_to_hsv_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// Shared definitions for the RGB->HSV colour-detect path.
package hsv_pkg;

  typedef enum logic [1:0] {
    SEC_R,
    SEC_G,
    SEC_B
  } sector_e;

  localparam int HUE_BASE_G = 120;
  localparam int HUE_BASE_B = 240;
  localparam int HUE_FULL   = 360;
  localparam int HUE_SCALE  = 60;

endpackage

// File: rtl/hsv_div_pipe.sv
// Pipelined restoring divider: one quotient bit per stage, MSB first.
// A zero denominator yields a zero quotient.
module hsv_div_pipe #(
  parameter int NW     = 14,
  parameter int DENW   = 8,
  parameter int QW     = 8,
  parameter int STAGES = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ce,
  input  logic [NW-1:0]   num,
  input  logic [DENW-1:0] den,
  output logic [QW-1:0]   quo
);

  localparam int CW = NW + DENW + QW;

  logic [NW-1:0]   rem_q [STAGES];
  logic [DENW-1:0] den_q [STAGES];
  logic [QW-1:0]   quo_q [STAGES];

  logic [NW-1:0]   rem_n [STAGES];
  logic [DENW-1:0] den_n [STAGES];
  logic [QW-1:0]   quo_n [STAGES];
  logic [CW-1:0]   trial;

  // Stage k resolves quotient bit QW-1-k; stages beyond QW only delay.
  always_comb begin
    trial    = '0;
    rem_n[0] = num;
    den_n[0] = den;
    quo_n[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      rem_n[k] = rem_q[k-1];
      den_n[k] = den_q[k-1];
      quo_n[k] = quo_q[k-1];
    end
    for (int k = 0; k < QW; k++) begin
      trial = CW'(den_n[k]) << (QW - 1 - k);
      if (CW'(rem_n[k]) >= trial) begin
        rem_n[k]             = NW'(CW'(rem_n[k]) - trial);
        quo_n[k][QW - 1 - k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        rem_q[k] <= '0;
        den_q[k] <= '0;
        quo_q[k] <= '0;
      end
    end else if (ce) begin
      for (int k = 0; k < STAGES; k++) begin
        rem_q[k] <= rem_n[k];
        den_q[k] <= den_n[k];
        quo_q[k] <= quo_n[k];
      end
    end
  end

  assign quo = (den_q[STAGES-1] == '0) ? '0 : quo_q[STAGES-1];

endmodule

// File: rtl/rgb_to_hsv_pipe.sv
// Fully pipelined RGB->HSV converter, one pixel per clock, with ce stall
// and sync flags delayed to match the DW+3 cycle data latency.
module rgb_to_hsv_pipe
  import hsv_pkg::*;
#(
  parameter int DW = 8,
  parameter int HW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic [DW-1:0] rgb_r,
  input  logic [DW-1:0] rgb_g,
  input  logic [DW-1:0] rgb_b,
  input  logic          vs,
  input  logic          hs,
  input  logic          de,
  input  logic          pixel_v,
  output logic [HW-1:0] hsv_h,
  output logic [DW-1:0] hsv_s,
  output logic [DW-1:0] hsv_v,
  output logic          hsv_vs,
  output logic          hsv_hs,
  output logic          hsv_de,
  output logic          hsv_valid
);

  localparam int LATENCY = DW + 3;
  localparam int NHW     = DW + 6;
  localparam int NSW     = 2 * DW;
  localparam int TW      = ((HW > DW) ? HW : DW) + 2;
  localparam logic [DW-1:0] SMAX = '1;

  sector_e       sec_c;
  logic [DW-1:0] max_c, min_c, dx_c, dy_c, mag_c;
  logic          neg_c;

  sector_e       sec_s1;
  logic [DW-1:0] max_s1, delta_s1, mag_s1;
  logic          neg_s1;

  sector_e        sec_s2;
  logic [NHW-1:0] nh_s2;
  logic [NSW-1:0] ns_s2;
  logic [DW-1:0]  delta_s2, max_s2;
  logic           neg_s2, grey_s2;

  logic [DW-1:0] qh, qs;

  sector_e       sec_d  [DW];
  logic [DW-1:0] max_d  [DW];
  logic          neg_d  [DW];
  logic          grey_d [DW];
  logic [3:0]    flag_d [LATENCY-1];

  logic [TW-1:0] base_c, hue_c;

  // Sector select with R > G > B priority on ties; d = dx - dy is kept as sign + magnitude.
  always_comb begin
    sec_c = SEC_R;
    max_c = rgb_r;
    min_c = (rgb_g < rgb_b) ? rgb_g : rgb_b;
    dx_c  = rgb_g;
    dy_c  = rgb_b;
    if (rgb_r >= rgb_g && rgb_r >= rgb_b) begin
      sec_c = SEC_R;
    end else if (rgb_g >= rgb_b) begin
      sec_c = SEC_G;
      max_c = rgb_g;
      min_c = (rgb_r < rgb_b) ? rgb_r : rgb_b;
      dx_c  = rgb_b;
      dy_c  = rgb_r;
    end else begin
      sec_c = SEC_B;
      max_c = rgb_b;
      min_c = (rgb_r < rgb_g) ? rgb_r : rgb_g;
      dx_c  = rgb_r;
      dy_c  = rgb_g;
    end
    neg_c = (dx_c < dy_c);
    mag_c = neg_c ? (dy_c - dx_c) : (dx_c - dy_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_s1   <= SEC_R;
      max_s1   <= '0;
      delta_s1 <= '0;
      mag_s1   <= '0;
      neg_s1   <= 1'b0;
      sec_s2   <= SEC_R;
      nh_s2    <= '0;
      ns_s2    <= '0;
      delta_s2 <= '0;
      max_s2   <= '0;
      neg_s2   <= 1'b0;
      grey_s2  <= 1'b0;
    end else if (ce) begin
      sec_s1   <= sec_c;
      max_s1   <= max_c;
      delta_s1 <= max_c - min_c;
      mag_s1   <= mag_c;
      neg_s1   <= neg_c;
      sec_s2   <= sec_s1;
      nh_s2    <= NHW'(mag_s1) * NHW'(HUE_SCALE);
      ns_s2    <= NSW'(delta_s1) * NSW'(SMAX);
      delta_s2 <= delta_s1;
      max_s2   <= max_s1;
      neg_s2   <= neg_s1;
      grey_s2  <= (delta_s1 == '0);
    end
  end

  hsv_div_pipe #(.NW(NHW), .DENW(DW), .QW(DW), .STAGES(DW)) u_div_hue (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .num     (nh_s2),
    .den     (delta_s2),
    .quo     (qh)
  );

  hsv_div_pipe #(.NW(NSW), .DENW(DW), .QW(DW), .STAGES(DW)) u_div_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .num     (ns_s2),
    .den     (max_s2),
    .quo     (qs)
  );

  // Side data rides alongside the dividers; flags bypass everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DW; k++) begin
        sec_d[k]  <= SEC_R;
        max_d[k]  <= '0;
        neg_d[k]  <= 1'b0;
        grey_d[k] <= 1'b0;
      end
      for (int k = 0; k < LATENCY - 1; k++) begin
        flag_d[k] <= '0;
      end
    end else if (ce) begin
      sec_d[0]  <= sec_s2;
      max_d[0]  <= max_s2;
      neg_d[0]  <= neg_s2;
      grey_d[0] <= grey_s2;
      for (int k = 1; k < DW; k++) begin
        sec_d[k]  <= sec_d[k-1];
        max_d[k]  <= max_d[k-1];
        neg_d[k]  <= neg_d[k-1];
        grey_d[k] <= grey_d[k-1];
      end
      flag_d[0] <= {vs, hs, de, pixel_v};
      for (int k = 1; k < LATENCY - 1; k++) begin
        flag_d[k] <= flag_d[k-1];
      end
    end
  end

  // Red sector with negative d wraps below zero to 360-qh; exactly 360 folds to 0.
  always_comb begin
    case (sec_d[DW-1])
      SEC_G:   base_c = TW'(HUE_BASE_G);
      SEC_B:   base_c = TW'(HUE_BASE_B);
      default: base_c = '0;
    endcase
    if (grey_d[DW-1]) begin
      hue_c = '0;
    end else if (!neg_d[DW-1]) begin
      hue_c = base_c + TW'(qh);
    end else if (sec_d[DW-1] == SEC_R) begin
      hue_c = TW'(HUE_FULL) - TW'(qh);
    end else begin
      hue_c = base_c - TW'(qh);
    end
    if (hue_c == TW'(HUE_FULL)) begin
      hue_c = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsv_h     <= '0;
      hsv_s     <= '0;
      hsv_v     <= '0;
      hsv_vs    <= 1'b0;
      hsv_hs    <= 1'b0;
      hsv_de    <= 1'b0;
      hsv_valid <= 1'b0;
    end else if (ce) begin
      hsv_h     <= HW'(hue_c);
      hsv_s     <= grey_d[DW-1] ? '0 : qs;
      hsv_v     <= max_d[DW-1];
      hsv_vs    <= flag_d[LATENCY-2][3];
      hsv_hs    <= flag_d[LATENCY-2][2];
      hsv_de    <= flag_d[LATENCY-2][1];
      hsv_valid <= flag_d[LATENCY-2][0];
    end
  end

endmodule

// File: tb/tb_rgb_to_hsv_pipe.sv
// Scoreboard bench for rgb_to_hsv_pipe: directed pixels with hand-computed HSV,
// ce stall, and mid-stream reset with latency measurement.
module tb_rgb_to_hsv_pipe;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic [7:0] rgb_r, rgb_g, rgb_b;
  logic       vs, hs, de, pixel_v;
  logic [8:0] hsv_h;
  logic [7:0] hsv_s, hsv_v;
  logic       hsv_vs, hsv_hs, hsv_de, hsv_valid;

  typedef struct {
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic       vs;
    logic       hs;
    logic       de;
  } exp_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;
  } vec_t;

  // r, g, b -> expected h, s, v
  vec_t vecs [14] = '{
    '{8'd255, 8'd0,   8'd0,   9'd0,   8'd255, 8'd255},
    '{8'd0,   8'd255, 8'd0,   9'd120, 8'd255, 8'd255},
    '{8'd0,   8'd0,   8'd255, 9'd240, 8'd255, 8'd255},
    '{8'd255, 8'd0,   8'd128, 9'd330, 8'd255, 8'd255},
    '{8'd200, 8'd200, 8'd0,   9'd60,  8'd255, 8'd200},
    '{8'd100, 8'd100, 8'd100, 9'd0,   8'd0,   8'd100},
    '{8'd0,   8'd0,   8'd0,   9'd0,   8'd0,   8'd0  },
    '{8'd255, 8'd0,   8'd1,   9'd0,   8'd255, 8'd255},
    '{8'd0,   8'd255, 8'd255, 9'd180, 8'd255, 8'd255},
    '{8'd100, 8'd50,  8'd25,  9'd20,  8'd191, 8'd100},
    '{8'd10,  8'd20,  8'd40,  9'd220, 8'd191, 8'd40 },
    '{8'd128, 8'd255, 8'd0,   9'd90,  8'd255, 8'd255},
    '{8'd1,   8'd0,   8'd0,   9'd0,   8'd255, 8'd1  },
    '{8'd50,  8'd60,  8'd70,  9'd210, 8'd72,  8'd70 }
  };

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  rgb_to_hsv_pipe #(.DW(8), .HW(9)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .rgb_r     (rgb_r),
    .rgb_g     (rgb_g),
    .rgb_b     (rgb_b),
    .vs        (vs),
    .hs        (hs),
    .de        (de),
    .pixel_v   (pixel_v),
    .hsv_h     (hsv_h),
    .hsv_s     (hsv_s),
    .hsv_v     (hsv_v),
    .hsv_vs    (hsv_vs),
    .hsv_hs    (hsv_hs),
    .hsv_de    (hsv_de),
    .hsv_valid (hsv_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if (hsv_h !== e.h || hsv_s !== e.s || hsv_v !== e.v || hsv_vs !== e.vs ||
        hsv_hs !== e.hs || hsv_de !== e.de || hsv_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s: got h=%0d s=%0d v=%0d vs/hs/de/valid=%b%b%b%b, want h=%0d s=%0d v=%0d vs/hs/de/valid=%b%b%b1",
               name, hsv_h, hsv_s, hsv_v, hsv_vs, hsv_hs, hsv_de, hsv_valid,
               e.h, e.s, e.v, e.vs, e.hs, e.de);
    end
  endtask

  task automatic checkZero(input string name);
    checks++;
    if ({hsv_h, hsv_s, hsv_v, hsv_vs, hsv_hs, hsv_de, hsv_valid} !== '0) begin
      errors++;
      $display("[TB] FAIL %s: got h=%0d s=%0d v=%0d vs/hs/de/valid=%b%b%b%b, want all zero",
               name, hsv_h, hsv_s, hsv_v, hsv_vs, hsv_hs, hsv_de, hsv_valid);
    end
  endtask

  // Drives one cycle of inputs at posedge+1 and queues the expected result for valid pixels.
  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic fvs, input logic fhs, input logic fde, input logic fpv,
                               input logic [8:0] eh, input logic [7:0] es, input logic [7:0] ev);
    exp_t e;
    rgb_r   = r;
    rgb_g   = g;
    rgb_b   = b;
    vs      = fvs;
    hs      = fhs;
    de      = fde;
    pixel_v = fpv;
    if (fpv && ce) begin
      e.h  = eh;
      e.s  = es;
      e.v  = ev;
      e.vs = fvs;
      e.hs = fhs;
      e.de = fde;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 8'd0);
    end
  endtask

  // Monitor: pops one expectation per ce-advanced valid output; holds the last one during stalls.
  logic ce_s;
  logic have_last = 1'b0;
  exp_t last_exp;
  exp_t mon_e;

  initial begin
    forever begin
      @(posedge clk);
      ce_s = ce;
      @(negedge clk);
      if (!reset_n) begin
        have_last = 1'b0;
      end else if (ce_s) begin
        if (hsv_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got h=%0d s=%0d v=%0d with valid=1, want no output",
                     hsv_h, hsv_s, hsv_v);
            have_last = 1'b0;
          end else begin
            mon_e = sb.pop_front();
            checkOutput("pixel", mon_e);
            last_exp  = mon_e;
            have_last = 1'b1;
          end
        end else begin
          have_last = 1'b0;
        end
      end else if (have_last) begin
        checkOutput("stall_hold", last_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion by 100000, want finish");
    $fatal(1, "[TB] timeout");
  end

  int lat;

  initial begin
    reset_n = 1'b0;
    ce      = 1'b0;
    rgb_r   = '0;
    rgb_g   = '0;
    rgb_b   = '0;
    vs      = 1'b0;
    hs      = 1'b0;
    de      = 1'b0;
    pixel_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkZero("reset_state");
    reset_n = 1'b1;
    ce      = 1'b1;

    $display("[TB] directed pixels");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].r, vecs[i].g, vecs[i].b, (i == 0), (i % 2 == 1), 1'b1, 1'b1,
                    vecs[i].h, vecs[i].s, vecs[i].v);
    end
    idleCycles(14);

    $display("[TB] stream with flags and ce stall");
    for (int i = 0; i < 20; i++) begin
      if (i == 12) begin
        ce = 1'b0;
        for (int k = 0; k < 5; k++) begin
          rgb_r   = 8'($urandom);
          rgb_g   = 8'($urandom);
          rgb_b   = 8'($urandom);
          vs      = 1'($urandom);
          hs      = 1'($urandom);
          de      = 1'($urandom);
          pixel_v = 1'b1;
          @(posedge clk);
          #1;
        end
        ce = 1'b1;
      end
      applyStimulus(vecs[i % 14].r, vecs[i % 14].g, vecs[i % 14].b,
                    (i % 2 == 1), ((i / 2) % 2 == 1), ((i / 4) % 2 == 0), (i % 5 != 3),
                    vecs[i % 14].h, vecs[i % 14].s, vecs[i % 14].v);
    end
    idleCycles(14);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].r, vecs[i].g, vecs[i].b, 1'b0, 1'b1, (i % 2 == 1), 1'b1,
                    vecs[i].h, vecs[i].s, vecs[i].v);
    end
    reset_n = 1'b0;
    pixel_v = 1'b0;
    #1;
    checkZero("reset_async");
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkZero("reset_hold");
    reset_n = 1'b1;
    applyStimulus(8'd0, 8'd255, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 9'd120, 8'd255, 8'd255);
    rgb_r   = '0;
    rgb_g   = '0;
    rgb_b   = '0;
    vs      = 1'b0;
    hs      = 1'b0;
    de      = 1'b0;
    pixel_v = 1'b0;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (hsv_valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 11) begin
      errors++;
      $display("[TB] FAIL restart_latency: got %0d cycles, want 11", lat);
    end

    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pixels outstanding, want 0", sb.size());
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
